// File: rtl/systolic_matmul.sv
// -----------------------------------------------------------------------------
// systolic_matmul
//   N x N output-stationary systolic matrix multiplier computing C = A * B,
//   where A is N x K and B is K x N and K is set at runtime by in_last. Operand
//   vectors arrive unskewed, one k per beat; the block skews them internally.
//   Accumulators can be kept across jobs (acc_en) so that K can be tiled.
//
// Ports
//   clk        clock, all state changes on the rising edge
//   reset_n    asynchronous active-low reset
//   start      begin a job (sampled only in IDLE)
//   acc_en     sampled with start: 1 keeps previous C, 0 clears it
//   in_valid   operand beat valid        in_ready  high only in LOAD
//   in_last    final beat of the job (k = K-1)
//   a_col      a_col[i*DW +: DW] = A[i][k]
//   b_row      b_row[j*DW +: DW] = B[k][j]
//   out_valid  results available (DONE)  out_ready result accepted
//   c_flat     c_flat[(i*N+j)*ACCW +: ACCW] = C[i][j]
//   busy       high whenever the block is not IDLE
// -----------------------------------------------------------------------------
module systolic_matmul #(
  parameter int N      = 2,
  parameter int DW     = 8,
  parameter int ACCW   = 16,
  parameter int SIGNED = 0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   acc_en,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_last,
  input  logic [N*DW-1:0]        a_col,
  input  logic [N*DW-1:0]        b_row,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [N*N*ACCW-1:0]    c_flat,
  output logic                   busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN,
    S_DONE
  } state_t;

  // Wide enough to hold 2N-1 (N=1 needs one bit, N=8 needs four).
  localparam int CW = $clog2(2 * N);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          job_start;
  logic          beat;

  assign job_start = (state_q == S_IDLE) && start;
  assign beat      = (state_q == S_LOAD) && in_valid;

  assign in_ready  = (state_q == S_LOAD);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, whatever the block order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_LOAD;
      S_LOAD: begin
        if (beat && in_last) begin
          state_d = S_DRAIN;
          cnt_d   = CW'(2 * N - 1);
        end
      end
      S_DRAIN: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_d == '0) state_d = S_DONE;
      end
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Product term: 2*DW-bit product, sign- or zero-extended to ACCW.
  // ---------------------------------------------------------------------------
  function automatic logic [ACCW-1:0] mac_term(input logic [DW-1:0] a,
                                               input logic [DW-1:0] b);
    logic [2*DW-1:0] p;
    if (SIGNED != 0) begin
      p = $signed({{DW{a[DW-1]}}, a}) * $signed({{DW{b[DW-1]}}, b});
      return ACCW'($signed(p));
    end else begin
      p = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
      return ACCW'(p);
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Input skew: lane i is delayed i cycles. Lanes carry zero unless a beat is
  // accepted, which is what makes bubbles and drain cycles harmless.
  // ---------------------------------------------------------------------------
  logic [DW-1:0] a_edge [N];
  logic [DW-1:0] b_edge [N];

  for (genvar gi = 0; gi < N; gi++) begin : g_skew
    logic [DW-1:0] a_in, b_in;
    assign a_in = beat ? a_col[gi*DW +: DW] : '0;
    assign b_in = beat ? b_row[gi*DW +: DW] : '0;

    if (gi == 0) begin : g_direct
      assign a_edge[gi] = a_in;
      assign b_edge[gi] = b_in;
    end else begin : g_delay
      logic [DW-1:0] a_dly [gi];
      logic [DW-1:0] b_dly [gi];

      // NOTE: the skew, operand and accumulator arrays are real registers, not
      // RAM, and all of them take the async reset because c_flat must read
      // zero the moment reset_n falls.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          for (int d = 0; d < gi; d++) begin
            a_dly[d] <= '0;
            b_dly[d] <= '0;
          end
        end else if (job_start) begin
          for (int d = 0; d < gi; d++) begin
            a_dly[d] <= '0;
            b_dly[d] <= '0;
          end
        end else begin
          a_dly[0] <= a_in;
          b_dly[0] <= b_in;
          for (int d = 1; d < gi; d++) begin
            a_dly[d] <= a_dly[d-1];
            b_dly[d] <= b_dly[d-1];
          end
        end
      end

      assign a_edge[gi] = a_dly[gi-1];
      assign b_edge[gi] = b_dly[gi-1];
    end
  end

  // ---------------------------------------------------------------------------
  // PE array: a moves right, b moves down, C stays put.
  // ---------------------------------------------------------------------------
  logic [DW-1:0]   a_out [N][N];
  logic [DW-1:0]   b_out [N][N];

  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      logic [DW-1:0]   a_pe, b_pe, a_q, b_q;
      logic [ACCW-1:0] acc_q;

      if (gj == 0) begin : g_a_edge
        assign a_pe = a_edge[gi];
      end else begin : g_a_chain
        assign a_pe = a_out[gi][gj-1];
      end

      if (gi == 0) begin : g_b_edge
        assign b_pe = b_edge[gj];
      end else begin : g_b_chain
        assign b_pe = b_out[gi-1][gj];
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          a_q   <= '0;
          b_q   <= '0;
          acc_q <= '0;
        end else if (job_start) begin
          a_q <= '0;
          b_q <= '0;
          if (!acc_en) acc_q <= '0;
        end else begin
          a_q   <= a_pe;
          b_q   <= b_pe;
          acc_q <= acc_q + mac_term(a_pe, b_pe);
        end
      end

      assign a_out[gi][gj]                      = a_q;
      assign b_out[gi][gj]                      = b_q;
      assign c_flat[(gi*N+gj)*ACCW +: ACCW]     = acc_q;
    end
  end

endmodule

// File: doc/systolic_matmul.md
# systolic_matmul

Parametrised N×N output-stationary systolic matrix multiplier, successor to the fixed 2×2 matmul core. It accepts unskewed column/row vectors over a valid/ready stream, performs the input skewing internally, and supports a runtime inner dimension K, signed or unsigned operands, and accumulation across jobs for K-tiling. It sits between the operand streamers and the result writeback, with a valid/ready handshake on both sides.

## Interface
- N, default 2: array dimension, 1..8; the block computes C = A·B with A N×K and B K×N.
- DW, default 8: operand width.
- ACCW, default 16: accumulator and result width; must be ≥ 2·DW.
- SIGNED, default 0: 0 treats operands as unsigned; 1 treats them as two's complement.
- clk  in  1  clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  begins a job; sampled only in IDLE.
- acc_en  in  1  sampled with start; 1 keeps the previous C in the accumulators and adds to it; 0 clears them.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  high only in LOAD.
- in_last  in  1  marks the final beat (k = K-1) of the job.
- a_col  in  N·DW  beat k: a_col[i·DW +: DW] = A[i][k].
- b_row  in  N·DW  beat k: b_row[j·DW +: DW] = B[k][j].
- out_valid  out  1  results available; high only in DONE.
- out_ready  in  1  result consumer accept.
- c_flat  out  N·N·ACCW  c_flat[(i·N+j)·ACCW +: ACCW] = C[i][j].
- busy  out  1  high whenever state ≠ IDLE.

## Operation
- States are IDLE, LOAD, DRAIN and DONE.
- IDLE → LOAD on start. On that edge the skew registers and PE operand registers clear. Accumulators clear unless acc_en=1.
- LOAD accepts a beat on in_valid && in_ready. If in_last is also set, the state goes to DRAIN and the drain counter loads 2N-1.
- DRAIN decrements the counter each cycle. When it reaches 0, the state goes to DONE.
- DONE → IDLE on out_ready.
- start is ignored outside IDLE. in_valid is ignored outside LOAD.
- Skew: row lane i of A and column lane j of B each pass through i (resp. j) delay registers before entering the array edge.
- PE(i,j) registers a to the right and b downward. Every cycle it adds a·b into acc[i][j].
- The array shifts every cycle. In any cycle without an accepted beat (bubbles, DRAIN, IDLE, DONE), zeros are injected on all lanes. Bubbles therefore never corrupt results.
- Arithmetic: the product is 2·DW wide, sign- or zero-extended per SIGNED, then added to the accumulator modulo 2^ACCW. Overflow wraps silently; there is no saturation.
- c_flat drives the accumulators directly. In DONE it is stable until accepted, because only zeros are being injected.
- Every job needs at least one beat. in_last on the first beat means K = 1.

## Timing
- Reset values: state IDLE, all accumulators and skew/PE registers 0, c_flat 0, in_ready 0, out_valid 0, busy 0.
- Asserting reset_n low at any time, including mid-LOAD or DRAIN, returns the block to these values immediately. The job is discarded.
- in_ready rises in the cycle after the start edge.
- Latency: out_valid rises exactly 2N-1 cycles after the edge that accepts the in_last beat. That is 3 cycles for N=2 and 1 cycle for N=1.
- Throughput: one beat per cycle. Job-to-job gap is 2N-1 drain cycles + ≥1 DONE cycle + 1 IDLE cycle.
- out_valid falls on the edge where out_valid && out_ready. start in that same cycle is ignored; it takes effect only in IDLE.

## Test plan
- Basic (N=2, DW=8, ACCW=16, unsigned): A=[[1,2],[3,4]], B=[[5,6],[7,8]] sent in 2 back-to-back beats. Required: C = 19, 22, 43, 50, with out_valid high exactly 3 cycles after the last beat.
- Wrap: all operands 0xFF. Required: every C element = 0xFC02.
- Bubbles: same as Basic, but in_valid is low for 3 cycles between beat 0 and beat 1. Required: identical C and latency measured from the last beat.
- Accumulate: Basic job, then start with acc_en=1 and K=1, beat a_col={1,1}, b_row={1,1}. Required: C = 20, 23, 44, 51. A following start with acc_en=0 and the same beat must give all 1s.
- Backpressure: out_ready held low for 5 cycles in DONE, with start pulsed during them. Required: c_flat stable, out_valid held, start ignored, busy=1. The block returns to IDLE one cycle after out_ready.
- Signed N=3 and reset: SIGNED=1, A = -1·I, B=[[1,2,3],[4,5,6],[7,8,9]]. Required: C = -B (C[0][0]=0xFFFF). Then assert reset_n low mid-LOAD. Required: all outputs 0 and state IDLE immediately; a subsequent job computes correctly.
